// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the scanning word selector.
// Imported by the selector and the sequencer top.
package mux_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_N_IN   = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_seq_stream_mux_n.sv
// Combinational N:1 word selector over a flat bus.
// Out-of-range indices select zero.
module mux_n
  import mux_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_IN   = DEF_N_IN,
  parameter int SEL_W  = clog2(N_IN)
) (
  input  logic [N_IN*DATA_W-1:0] in_flat,
  input  logic [SEL_W-1:0]       sel,
  output logic [DATA_W-1:0]      y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (int'(sel) == k) y = in_flat[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/mux_seq_stream.sv
// N:1 word selector with a scan sequencer streaming words
// over a valid/ready output; manual lookup while idle.
module mux_seq_stream
  import mux_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_IN   = DEF_N_IN,
  parameter int SEL_W  = clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_IN*DATA_W-1:0] in_flat,
  input  logic                   start,
  input  logic [SEL_W-1:0]       base,
  input  logic [SEL_W:0]         count,
  input  logic [SEL_W-1:0]       sel_manual,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_IN - 1);
  localparam logic [SEL_W:0]   ONE  = (SEL_W+1)'(1);

  state_t             state;
  logic [SEL_W-1:0]   idx;
  logic [SEL_W:0]     rem;
  logic [SEL_W-1:0]   msel;
  logic [DATA_W-1:0]  word;
  logic               load;
  logic               bad;

  assign msel = (state == IDLE) ? sel_manual : idx;
  assign load = !out_valid || out_ready;
  assign bad  = (int'(base) >= N_IN) || (int'(count) > N_IN);
  assign busy = (state != IDLE);

  mux_n #(
    .DATA_W (DATA_W),
    .N_IN   (N_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .in_flat (in_flat),
    .sel     (msel),
    .y       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      rem       <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          out_data  <= word;
          out_idx   <= sel_manual;
          out_valid <= 1'b0;
          if (start) begin
            if (bad) begin
              err <= 1'b1;
            end else if (count == '0) begin
              done <= 1'b1;
            end else begin
              idx   <= base;
              rem   <= count;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (load) begin
            out_data  <= word;
            out_idx   <= idx;
            out_valid <= 1'b1;
            idx       <= (idx == LAST) ? '0 : idx + 1'b1;
            rem       <= rem - ONE;
            if (rem == ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          // last beat waits here until the consumer takes it
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
